// File: rtl/spi_peripheral_pkg.sv
// rtl/spi_peripheral_pkg.sv - register map, frame size and FSM state encoding for spi_peripheral
package spi_pkg;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;
   localparam logic [6:0] ADDR_MAX       = ADDR_DUTY;

   localparam int FRAME_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - SPI pin bundle with controller and target views
interface spi_peripheral_if;
   logic sclk;
   logic copi;
   logic ncs;
   logic cipo;

   modport master (output sclk, output copi, output ncs, input cipo);
   modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered-history rise/fall pulses
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= sync[STAGES-1];
      end
   end

   assign level = sync[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI target holding the five PWM control registers
// Optional SPI_READBACK_EN builds the cipo output shifter for read frames.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_peripheral_if.slave  spi,
   output logic [7:0]       en_reg_out_7_0,
   output logic [7:0]       en_reg_out_15_8,
   output logic [7:0]       en_reg_pwm_7_0,
   output logic [7:0]       en_reg_pwm_15_8,
   output logic [7:0]       pwm_duty_cycle
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SHIFT  = ST_SHIFT;
   localparam logic [1:0] S_COMMIT = ST_COMMIT;
   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic copi_lvl, copi_rise, copi_fall;
   logic ncs_lvl, ncs_rise, ncs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .rst_n(rst_n), .din(spi.sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_copi (
      .clk(clk), .rst_n(rst_n), .din(spi.copi),
      .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
      .clk(clk), .rst_n(rst_n), .din(spi.ncs),
      .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
   );

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [15:0] shreg;
   logic        frame_ok;

   // Only an exact 16-bit write to a mapped address may touch the registers.
   assign frame_ok = (cnt == CNT_FULL) && shreg[15] && (shreg[14:8] <= ADDR_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= 5'd0;
         shreg           <= 16'h0000;
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (ncs_fall) begin
                  state <= S_SHIFT;
                  cnt   <= 5'd0;
                  shreg <= 16'h0000;
               end
            end
            S_SHIFT: begin
               // A chip-select release wins over an sclk edge seen in the same cycle.
               if (ncs_rise) begin
                  state <= S_COMMIT;
               end else if (sclk_rise) begin
                  shreg <= {shreg[14:0], copi_lvl};
                  if (cnt != CNT_SAT) begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            S_COMMIT: begin
               state <= S_IDLE;
               if (frame_ok) begin
                  case (shreg[14:8])
                     ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
                     ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
                     ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
                     ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
                     ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
                     default: ;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SPI_READBACK_EN
   logic [7:0] sh_low;
   logic [7:0] rd_mux;
   logic [7:0] out_sh;
   logic       unused_edges;

   assign sh_low       = {shreg[6:0], copi_lvl};
   assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

   always_comb begin
      rd_mux = 8'h00;
      case (sh_low[6:0])
         ADDR_EN_OUT_LO: rd_mux = en_reg_out_7_0;
         ADDR_EN_OUT_HI: rd_mux = en_reg_out_15_8;
         ADDR_EN_PWM_LO: rd_mux = en_reg_pwm_7_0;
         ADDR_EN_PWM_HI: rd_mux = en_reg_pwm_15_8;
         ADDR_DUTY:      rd_mux = pwm_duty_cycle;
         default:        rd_mux = 8'h00;
      endcase
   end

   // Load on the 8th rise; the fall right after it is skipped so bit 7 is sampled on rise 9.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sh <= 8'h00;
      end else if (state != S_SHIFT || ncs_rise) begin
         out_sh <= 8'h00;
      end else if (sclk_rise && cnt == 5'd7 && !sh_low[7]) begin
         out_sh <= rd_mux;
      end else if (sclk_fall && cnt >= 5'd9) begin
         out_sh <= {out_sh[6:0], 1'b0};
      end
   end

   assign spi.cipo = out_sh[7] & ~ncs_lvl & (state == S_SHIFT);
`else
   logic unused_edges;

   assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};
   assign spi.cipo     = 1'b0;
`endif

endmodule
